mem_store_ctrl: RTL and testbench

MEM_STORE_CTRL -- requirements
Module: mem_store_ctrl

---
 rtl/mem_store_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_store_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_ctrl.sv
// mem_store_ctrl: turns byte/halfword/word store requests into lane-ordered memory write beats.
// Optional feature macro: MISALIGN_SPLIT_EN splits word-crossing stores into two beats.
module mem_store_ctrl #(
    parameter logic [1:0] BYTE     = 2'b00,
    parameter logic [1:0] HALFWORD = 2'b01,
    parameter logic [1:0] WORD     = 2'b10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        done,
    output logic        err
);
    // Handshake rule for both ports: a transfer occurs on a rising edge where valid and ready
    // are both 1; while valid is 1 the payload holds steady until that edge.
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, data_q;
    logic [2:0]  len_q;
    logic        err_q;
    logic [2:0]  req_len;
    logic        req_illegal;
    logic [3:0]  len_mask;
    logic [31:0] data_m;

    always_comb begin
        req_len = 3'd0;
        case (req_size)
            BYTE:     req_len = 3'd1;
            HALFWORD: req_len = 3'd2;
            WORD:     req_len = 3'd4;
            default:  req_len = 3'd0;
        endcase
    end

`ifdef MISALIGN_SPLIT_EN
    logic [63:0] shifted;
    logic [7:0]  we_span;
    logic        cross;
    assign req_illegal = (req_len == 3'd0);
    assign cross       = ({1'b0, addr_q[1:0]} + len_q) > 3'd4;
    assign shifted     = {32'd0, data_m} << {addr_q[1:0], 3'b000};
    assign we_span     = {4'd0, len_mask} << addr_q[1:0];
`else
    logic [31:0] shifted;
    logic [3:0]  we_span;
    logic        req_cross;
    assign req_cross   = ({1'b0, req_addr[1:0]} + req_len) > 3'd4;
    assign req_illegal = (req_len == 3'd0) || req_cross;
    assign shifted     = data_m << {addr_q[1:0], 3'b000};
    assign we_span     = len_mask << addr_q[1:0];
`endif

    always_comb begin
        len_mask = 4'b0000;
        case (len_q)
            3'd1:    len_mask = 4'b0001;
            3'd2:    len_mask = 4'b0011;
            3'd4:    len_mask = 4'b1111;
            default: len_mask = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            data_m[8*i +: 8] = len_mask[i] ? data_q[8*i +: 8] : 8'h00;
        end
    end

    // Byte offset k of the word lives in the most-significant-first lane [31-8k -: 8].
    function automatic logic [31:0] lane_order(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[31-8*k -: 8] = v[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_we     = 4'd0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_illegal ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = lane_order(shifted[31:0]);
                mem_we    = we_span[3:0];
                if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
                    state_next = cross ? BEAT1 : RESP;
`else
                    state_next = RESP;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem_wdata = lane_order(shifted[63:32]);
                mem_we    = we_span[7:4];
                if (mem_ready) state_next = RESP;
            end
`endif
            RESP: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            len_q  <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (req_valid && req_ready) begin
                addr_q <= req_addr;
                data_q <= req_data;
                len_q  <= req_len;
                err_q  <= req_illegal;
            end
        end
    end
endmodule

// File: tb/tb_mem_store_ctrl.sv
// Self-checking bench for mem_store_ctrl: directed spec vectors, stalls, resets and random stores
// checked against a byte-placement reference model.
module tb_mem_store_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        done, err;

    int errors = 0;
    int checks = 0;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    mem_store_ctrl dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Observations from the last drive_store call
    logic [31:0] ob_addr[$];
    logic [3:0]  ob_we[$];
    logic [31:0] ob_wd[$];
    int          ob_c[$];
    logic [31:0] st_addr[$];
    logic [3:0]  st_we[$];
    logic [31:0] st_wd[$];
    int          done_c, n_done;
    logic        err_o, ready_at_done;

    // Reference model outputs
    bit          m_legal;
    int          m_nb;
    logic [31:0] m_addr[2];
    logic [3:0]  m_we[2];
    logic [31:0] m_wd[2];
    logic [31:0] exp_q[$];

    // Byte i of the value lands at absolute byte position off+i; position/4 picks the beat,
    // position%4 the lane, and lane k sits at bits [31-8k -: 8].
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n, off, pos, b, ln;
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 0;
        off = int'(a[1:0]);
        m_legal = (n != 0) && (SPLIT || (off + n <= 4));
        m_nb = !m_legal ? 0 : (off + n > 4) ? 2 : 1;
        m_addr[0] = {a[31:2], 2'b00};
        m_addr[1] = m_addr[0] + 32'd4;
        m_we[0] = 4'd0; m_we[1] = 4'd0;
        m_wd[0] = 32'd0; m_wd[1] = 32'd0;
        for (int i = 0; i < n; i++) begin
            pos = off + i;
            b = pos / 4;
            ln = pos % 4;
            m_we[b][ln] = 1'b1;
            m_wd[b][31-8*ln -: 8] = d[8*i +: 8];
        end
    endtask

    // Issues one request from idle and watches 8 cycles; the first beat is stalled 'stall' cycles.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                               input int stall);
        int left;
        ob_addr.delete(); ob_we.delete(); ob_wd.delete(); ob_c.delete();
        st_addr.delete(); st_we.delete(); st_wd.delete();
        done_c = -1; n_done = 0; err_o = 1'b0; ready_at_done = 1'b0;
        left = stall;
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom_range(0, 3));
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_valid) begin
                if (left > 0) begin
                    mem_ready = 1'b0;
                    left--;
                    st_addr.push_back(mem_addr); st_we.push_back(mem_we); st_wd.push_back(mem_wdata);
                end else begin
                    mem_ready = 1'b1;
                    ob_addr.push_back(mem_addr); ob_we.push_back(mem_we); ob_wd.push_back(mem_wdata);
                    ob_c.push_back(c);
                end
            end else begin
                mem_ready = 1'b1;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_c = c; err_o = err; ready_at_done = req_ready;
                end
            end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b1; req_addr = 32'h104; req_data = 32'hFFFFFFFF;
        req_size = 2'b10; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (mem_we !== 4'd0) begin errors++; $display("FAIL reset_mem_we: got %b want 0000", mem_we); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        req_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL idle_mem_valid: got %b want 0", mem_valid); end
    endtask

    task automatic test_directed();
        drive_store(32'h100, 32'h11223344, 2'b10, 0);
        checks++; if (ob_addr.size() !== 1) begin errors++; $display("FAIL sw_beats: got %0d want 1", ob_addr.size()); end
        if (ob_addr.size() >= 1) begin
            checks++; if (ob_addr[0] !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h want 00000100", ob_addr[0]); end
            checks++; if (ob_we[0] !== 4'b1111) begin errors++; $display("FAIL sw_we: got %b want 1111", ob_we[0]); end
            checks++; if (ob_wd[0] !== 32'h44332211) begin errors++; $display("FAIL sw_wdata: got %h want 44332211", ob_wd[0]); end
            checks++; if (ob_c[0] !== 1) begin errors++; $display("FAIL sw_beat_latency: got %0d want 1", ob_c[0]); end
        end
        checks++; if (done_c !== 2 || err_o !== 1'b0) begin errors++; $display("FAIL sw_done: got cyc %0d err %b want cyc 2 err 0", done_c, err_o); end

        drive_store(32'h103, 32'h000000AB, 2'b00, 0);
        checks++; if (ob_addr.size() !== 1 || ob_addr[0] !== 32'h100 || ob_we[0] !== 4'b1000 || ob_wd[0] !== 32'h000000AB) begin
            errors++; $display("FAIL sb_beat: got n=%0d addr %h we %b wd %h want 00000100 1000 000000ab",
                               ob_addr.size(), ob_addr.size() ? ob_addr[0] : 32'h0, ob_we.size() ? ob_we[0] : 4'h0, ob_wd.size() ? ob_wd[0] : 32'h0); end

        drive_store(32'h102, 32'h0000BEEF, 2'b01, 0);
        checks++; if (ob_addr.size() !== 1 || ob_we[0] !== 4'b1100 || ob_wd[0] !== 32'h0000EFBE) begin
            errors++; $display("FAIL sh_beat: got n=%0d we %b wd %h want 1100 0000efbe",
                               ob_addr.size(), ob_we.size() ? ob_we[0] : 4'h0, ob_wd.size() ? ob_wd[0] : 32'h0); end

        drive_store(32'h101, 32'h11223344, 2'b10, 0);
`ifdef MISALIGN_SPLIT_EN
        checks++; if (ob_addr.size() !== 2) begin errors++; $display("FAIL split_beats: got %0d want 2", ob_addr.size()); end
        if (ob_addr.size() == 2) begin
            checks++; if (ob_addr[0] !== 32'h100 || ob_we[0] !== 4'b1110 || ob_wd[0] !== 32'h00443322) begin
                errors++; $display("FAIL split_beat0: got %h %b %h want 00000100 1110 00443322", ob_addr[0], ob_we[0], ob_wd[0]); end
            checks++; if (ob_addr[1] !== 32'h104 || ob_we[1] !== 4'b0001 || ob_wd[1] !== 32'h11000000) begin
                errors++; $display("FAIL split_beat1: got %h %b %h want 00000104 0001 11000000", ob_addr[1], ob_we[1], ob_wd[1]); end
        end
        checks++; if (done_c !== 3 || err_o !== 1'b0) begin errors++; $display("FAIL split_done: got cyc %0d err %b want 3 0", done_c, err_o); end
`else
        checks++; if (ob_addr.size() !== 0) begin errors++; $display("FAIL misalign_no_beat: got %0d beats want 0", ob_addr.size()); end
        checks++; if (done_c !== 1 || err_o !== 1'b1) begin errors++; $display("FAIL misalign_err: got cyc %0d err %b want 1 1", done_c, err_o); end
`endif
    endtask

    task automatic test_stall();
        drive_store(32'h100, 32'h11223344, 2'b10, 3);
        checks++; if (st_addr.size() !== 3) begin errors++; $display("FAIL stall_cycles: got %0d want 3", st_addr.size()); end
        for (int k = 0; k < st_addr.size(); k++) begin
            checks++; if (st_addr[k] !== 32'h100 || st_we[k] !== 4'b1111 || st_wd[k] !== 32'h44332211) begin
                errors++; $display("FAIL stall_stable[%0d]: got %h %b %h want 00000100 1111 44332211", k, st_addr[k], st_we[k], st_wd[k]); end
        end
        checks++; if (ob_c.size() !== 1 || ob_c[0] !== 4) begin errors++; $display("FAIL stall_accept: got n=%0d want beat at cycle 4", ob_c.size()); end
        checks++; if (done_c !== 5 || n_done !== 1) begin errors++; $display("FAIL stall_done: got cyc %0d pulses %0d want 5 1", done_c, n_done); end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        seen_done = 0;
        req_valid = 1'b1; req_addr = 32'h200; req_data = 32'hCAFEF00D; req_size = 2'b10; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_stalled_beat: got %b want 1", mem_valid); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_abandon: got valid %b ready %b done %b want 0 1 0", mem_valid, req_ready, done); end
        resetn = 1'b1; mem_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_valid) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen_done); end
    endtask

    task automatic test_illegal();
        drive_store(32'h300, 32'h12345678, 2'b11, 0);
        checks++; if (ob_addr.size() !== 0 || st_addr.size() !== 0) begin errors++; $display("FAIL illegal_no_beat: got %0d beats want 0", ob_addr.size()); end
        checks++; if (done_c !== 1 || err_o !== 1'b1 || n_done !== 1) begin
            errors++; $display("FAIL illegal_resp: got cyc %0d err %b pulses %0d want 1 1 1", done_c, err_o, n_done); end
        checks++; if (ready_at_done !== 1'b0) begin errors++; $display("FAIL illegal_ready_in_resp: got %b want 0", ready_at_done); end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  s;
        int          st;
        for (int t = 0; t < 60; t++) begin
            a = (t % 10 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            st = $urandom_range(0, 2);
            model(a, d, s);
            exp_q.delete();
            for (int k = 0; k < m_nb; k++) exp_q.push_back(m_wd[k]);
            drive_store(a, d, s, st);
            checks++; if (ob_addr.size() !== m_nb) begin
                errors++; $display("FAIL rand_beats[%0d]: got %0d want %0d (a=%h s=%0d)", t, ob_addr.size(), m_nb, a, s); end
            for (int k = 0; k < m_nb && k < ob_addr.size(); k++) begin
                checks++; if (ob_addr[k] !== m_addr[k] || ob_we[k] !== m_we[k] || ob_wd[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rand_beat[%0d.%0d]: got %h %b %h want %h %b %h", t, k,
                                       ob_addr[k], ob_we[k], ob_wd[k], m_addr[k], m_we[k], exp_q[k]); end
            end
            checks++; if (done_c !== (m_legal ? m_nb + 1 + st : 1) || err_o !== !m_legal || n_done !== 1) begin
                errors++; $display("FAIL rand_done[%0d]: got cyc %0d err %b pulses %0d want %0d %b 1", t,
                                   done_c, err_o, n_done, m_legal ? m_nb + 1 + st : 1, !m_legal); end
            checks++; if (ready_at_done !== 1'b0) begin errors++; $display("FAIL rand_ready_in_resp[%0d]: got %b want 0", t, ready_at_done); end
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_size = 2'b00; mem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
